// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports (instruction fetch, data) and the byte-wide memory port
// shared by mem_arbiter; the arbiter uses the slave modport, the core/memory side the master.
interface mem_arbiter_if #(
    parameter int ADDR_W     = 32,
    parameter int MEM_ADDR_W = 17
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [31:0]           if_rdata;
    logic                  if_done;

    logic                  d_req;
    logic                  d_we;
    logic [1:0]            d_len;
    logic [ADDR_W-1:0]     d_addr;
    logic [31:0]           d_wdata;
    logic [31:0]           d_rdata;
    logic                  d_done;

    logic [MEM_ADDR_W-1:0] mem_a;
    logic                  mem_wr;
    logic [7:0]            mem_dout;
    logic [7:0]            mem_din;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_len, d_addr, d_wdata, mem_din,
        output if_rdata, if_done, d_rdata, d_done, mem_a, mem_wr, mem_dout
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_len, d_addr, d_wdata, mem_din,
        input  if_rdata, if_done, d_rdata, d_done, mem_a, mem_wr, mem_dout
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide memory between the IF and D ports, splitting accesses into little-endian
// byte transactions. Define MEM_ARB_FAIR_EN for round-robin arbitration instead of D > IF.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MEM_ADDR_W = 17
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IF_BUSY,
        S_D_BUSY,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [2:0]            r_cnt;
    logic [2:0]            r_len_n;
    logic                  r_we;
    logic [MEM_ADDR_W-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_data;
`ifdef MEM_ARB_FAIR_EN
    logic                  r_last_d;
`endif

    logic                  w_grant_d;
    logic                  w_grant_if;
    logic [2:0]            w_d_n;
    logic [MEM_ADDR_W-1:0] w_grant_a;
    logic [MEM_ADDR_W-1:0] w_next_a;
    logic [1:0]            w_cap_idx;
    logic [31:0]           w_capture;
    logic [7:0]            w_wbyte;
    logic                  w_unused;

    always_comb begin
        w_d_n = (bus.d_len == 2'd0) ? 3'd1 : (bus.d_len == 2'd1) ? 3'd2 : 3'd4;
`ifdef MEM_ARB_FAIR_EN
        // On a tie the port that was not granted last wins.
        w_grant_d = bus.d_req && (!bus.if_req || !r_last_d);
`else
        w_grant_d = bus.d_req;
`endif
        w_grant_if = bus.if_req && !w_grant_d;
        w_grant_a  = w_grant_d ? bus.d_addr[MEM_ADDR_W-1:0] : bus.if_addr[MEM_ADDR_W-1:0];
        w_next_a   = r_addr + MEM_ADDR_W'(r_cnt);
        w_wbyte    = r_wdata[8*r_cnt[1:0] +: 8];
        // Memory returns data one cycle late, so the byte arriving now belongs to index cnt-2.
        w_cap_idx  = 2'(r_cnt - 3'd2);
        w_capture  = r_data;
        w_capture[8*w_cap_idx +: 8] = bus.mem_din;
    end

    assign w_unused = ^{bus.if_addr, bus.d_addr};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            r_len_n      <= 3'd0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_data       <= 32'd0;
`ifdef MEM_ARB_FAIR_EN
            r_last_d     <= 1'b0;
`endif
            bus.if_rdata <= 32'd0;
            bus.if_done  <= 1'b0;
            bus.d_rdata  <= 32'd0;
            bus.d_done   <= 1'b0;
            bus.mem_a    <= '0;
            bus.mem_wr   <= 1'b0;
            bus.mem_dout <= 8'd0;
        end else begin
            bus.if_done  <= 1'b0;
            bus.d_done   <= 1'b0;
            bus.mem_a    <= '0;
            bus.mem_wr   <= 1'b0;
            bus.mem_dout <= 8'd0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d || w_grant_if) begin
                        r_state      <= w_grant_d ? S_D_BUSY : S_IF_BUSY;
                        r_we         <= w_grant_d && bus.d_we;
                        r_len_n      <= w_grant_d ? w_d_n : 3'd4;
                        r_addr       <= w_grant_a;
                        r_wdata      <= bus.d_wdata;
                        r_data       <= 32'd0;
                        r_cnt        <= 3'd1;
                        bus.mem_a    <= w_grant_a;
                        bus.mem_wr   <= w_grant_d && bus.d_we;
                        bus.mem_dout <= (w_grant_d && bus.d_we) ? bus.d_wdata[7:0] : 8'd0;
`ifdef MEM_ARB_FAIR_EN
                        r_last_d     <= w_grant_d;
`endif
                    end
                end
                S_IF_BUSY, S_D_BUSY: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_we) begin
                        if (r_cnt == r_len_n) begin
                            r_state    <= S_DONE;
                            bus.d_done <= 1'b1;
                        end else begin
                            bus.mem_a    <= w_next_a;
                            bus.mem_wr   <= 1'b1;
                            bus.mem_dout <= w_wbyte;
                        end
                    end else begin
                        if (r_cnt >= 3'd2) begin
                            r_data <= w_capture;
                        end
                        if (r_cnt < r_len_n) begin
                            bus.mem_a <= w_next_a;
                        end
                        if (r_cnt == r_len_n + 3'd1) begin
                            r_state <= S_DONE;
                            if (r_state == S_D_BUSY) begin
                                bus.d_done  <= 1'b1;
                                bus.d_rdata <= w_capture;
                            end else begin
                                bus.if_done  <= 1'b1;
                                bus.if_rdata <= w_capture;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 3'd0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

endmodule
